// File: rtl/rc4_mem_pkg.sv
// rc4_mem_pkg: shared widths, requester count and owner tag for the RC4 RAM arbiter.
package rc4_mem_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;
    localparam int NUM_REQ    = 2;
    typedef logic owner_t;
endpackage

// File: rtl/rc4_rr_pick2.sv
// rc4_rr_pick2: combinational 2-way round-robin picker with lock override.
module rc4_rr_pick2
    import rc4_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  owner_t             last_grant,
    input  logic               lock_held,
    input  owner_t             lock_owner,
    output logic [NUM_REQ-1:0] grant
);
    always_comb begin
        grant = lock_held ? (valid & (2'b01 << lock_owner)) :
                (&valid)  ? (last_grant ? 2'b01 : 2'b10) : valid;
    end
endmodule

// File: rtl/rc4_mem_arbiter.sv
// rc4_mem_arbiter: round-robin arbiter sharing the RC4 single-port RAM between two requesters.
// Optional ownership lock for the S[i]/S[j] swap is enabled with MEM_ARB_LOCK_EN.
module rc4_mem_arbiter
    import rc4_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [2*ADDR_W-1:0]   req_address,
    input  logic [2*BE_W-1:0]     req_byteenable,
    input  logic [2*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]     rsp_readdata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);
    logic [NUM_REQ-1:0] grant;
    owner_t             last_grant, win, issue_tag, rsp_tag;
    logic               accept, rsp_arm, lock_held;
    owner_t             lock_owner;

    rc4_rr_pick2 u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .lock_held  (lock_held),
        .lock_owner (lock_owner),
        .grant      (grant)
    );

    // Ready is forced low while reset is asserted, even with requests pending.
    assign req_ready = grant & {NUM_REQ{reset_n}};
    assign accept    = |req_ready;
    assign win       = req_ready[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= 1'b1;
            mem_clken      <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            issue_tag      <= '0;
            rsp_arm        <= 1'b0;
            rsp_tag        <= '0;
        end else begin
            mem_clken      <= 1'b1;
            mem_chipselect <= accept;
            mem_write      <= accept & req_write[win];
            if (accept) begin
                last_grant     <= win;
                issue_tag      <= win;
                mem_address    <= win ? req_address[2*ADDR_W-1:ADDR_W] : req_address[ADDR_W-1:0];
                mem_byteenable <= win ? req_byteenable[2*BE_W-1:BE_W] : req_byteenable[BE_W-1:0];
                mem_writedata  <= win ? req_writedata[2*DATA_W-1:DATA_W] : req_writedata[DATA_W-1:0];
            end
            rsp_arm <= mem_chipselect & ~mem_write;
            rsp_tag <= issue_tag;
        end
    end

    assign rsp_valid    = rsp_arm ? (2'b01 << rsp_tag) : 2'b00;
    assign rsp_readdata = mem_readdata;

`ifdef MEM_ARB_LOCK_EN
    // Only the owner can be accepted while held, so every acceptance rewrites the lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_held  <= 1'b0;
            lock_owner <= '0;
        end else if (accept) begin
            lock_held  <= req_lock[win];
            lock_owner <= win;
        end
    end
`else
    logic unused_lock;
    assign lock_held   = 1'b0;
    assign lock_owner  = '0;
    assign unused_lock = ^req_lock;
`endif
endmodule

// File: tb/tb_rc4_mem_arbiter.sv
// tb_rc4_mem_arbiter: directed self-checking bench for rc4_mem_arbiter with a behavioural RAM.
module tb_rc4_mem_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [2*AW-1:0] req_address;
    logic [2*BW-1:0] req_byteenable;
    logic [2*DW-1:0] req_writedata;
    logic [DW-1:0] rsp_readdata, mem_writedata, mem_readdata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ram [0:32767];

    rc4_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_lock       (req_lock),
        .req_address    (req_address),
        .req_byteenable (req_byteenable),
        .req_writedata  (req_writedata),
        .rsp_valid      (rsp_valid),
        .rsp_readdata   (rsp_readdata),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // RAM registers the address on the access cycle; q appears in the following cycle.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req_valid[i]              = v;
        req_write[i]              = w;
        req_lock[i]               = l;
        req_address[i*AW +: AW]   = a;
        req_byteenable[i*BW +: BW] = be;
        req_writedata[i*DW +: DW] = d;
    endtask

    logic [1:0]    exp_lock [0:7];
    logic [AW-1:0] op_addr  [0:3];
    logic          op_wr    [0:3];
    logic          op_lock  [0:3];
    int            op_i;

    initial begin
        ram[15'h0010] = 32'hDEADBEEF;
        ram[15'h0020] = 32'h12345678;
        ram[15'h7FFF] = 32'hFFFFFFFF;
        mem_readdata  = '0;
        reset_n = 1'b0;
        req_valid = '0; req_write = '0; req_lock = '0;
        req_address = '0; req_byteenable = '0; req_writedata = '0;

        // Reset values, with both requests pending
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        step(); step();
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp", rsp_valid, 2'b00);
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_clken", mem_clken, 1'b0);
        req_valid = 2'b00;
        reset_n = 1'b1;
        step();
        check("clken_after_rst", mem_clken, 1'b1);
        check("idle_cs", mem_chipselect, 1'b0);

        // Single read from requester 0
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        #1 check("rd0_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("rd0_cs", mem_chipselect, 1'b1);
        check("rd0_we", mem_write, 1'b0);
        check("rd0_addr", mem_address, 15'h0010);
        step();
        check("rd0_rsp", rsp_valid, 2'b01);
        check("rd0_data", rsp_readdata, 32'hDEADBEEF);
        step();
        check("rd0_rsp_done", rsp_valid, 2'b00);

        // Reset during the issue cycle of a read
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        #1 check("mid_ready", req_ready, 2'b01);
        step();
        reset_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mid_cs", mem_chipselect, 1'b0);
        check("mid_ready_rst", req_ready, 2'b00);
        check("mid_rsp", rsp_valid, 2'b00);
        check("mid_clken", mem_clken, 1'b0);
        check("mid_addr", mem_address, 15'h0);
        step();
        check("mid_rsp_n2", rsp_valid, 2'b00);
        req_valid = 2'b00;
        reset_n = 1'b1;
        step();

        // Both requesters continuously valid: alternation, responses in grant order
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) req_valid = 2'b00;
            #1;
            if (k < 6) check($sformatf("rr_ready%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 2) begin
                check($sformatf("rr_rsp%0d", k), rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("rr_data%0d", k), rsp_readdata, (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
            end
            step();
        end

        // Partial write from requester 1, then read-back from requester 0
        set_req(1, 1'b1, 1'b1, 1'b0, 15'h7FFF, 4'b0011, 32'hA5A5A5A5);
        #1 check("wr1_ready", req_ready, 2'b10);
        step();
        check("wr1_we", mem_write, 1'b1);
        set_req(1, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 4'hF, 32'h0);
        #1 check("rb0_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("wr_no_rsp", rsp_valid, 2'b00);
        step();
        check("rb0_rsp", rsp_valid, 2'b01);
        check("rb0_data", rsp_readdata, 32'hFFFFA5A5);

        // Swap sequence from requester 0 with requester 1 valid throughout
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step();
        op_addr = '{15'h0010, 15'h0020, 15'h0100, 15'h0101};
        op_wr   = '{1'b0, 1'b0, 1'b1, 1'b1};
        op_lock = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef MEM_ARB_LOCK_EN
        exp_lock = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`else
        exp_lock = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        set_req(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
        op_i = 0;
        for (int c = 0; c < 8; c++) begin
            if (op_i < 4) set_req(0, 1'b1, op_wr[op_i], op_lock[op_i], op_addr[op_i], 4'hF, 32'h0BAD_0000 + op_i);
            else          set_req(0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
            #1;
            check($sformatf("lock_ready%0d", c), req_ready, exp_lock[c]);
            if (req_ready[0]) op_i++;
            step();
        end
        req_valid = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
